// File: rtl/vc_input_buffer_if.sv
// Link-side and switch-side signal bundle for a virtual-channel router input port.
// The master drives flits and pops; the slave (the buffer) answers with status and credits.
interface vc_input_buffer_if #(
    parameter int unsigned VC_NUM = 2,
    parameter int unsigned VC_W   = 1,
    parameter int unsigned FLIT_W = 25
);
    logic              valid_i;
    logic [FLIT_W-1:0] flit_i;
    logic              read_i;
    logic [VC_W-1:0]   read_vc_i;
    logic [FLIT_W-1:0] flit_o;
    logic [VC_NUM-1:0] empty_o;
    logic [VC_NUM-1:0] full_o;
    logic [VC_NUM-1:0] head_o;
    logic              credit_o;
    logic [VC_W-1:0]   credit_vc_o;
    logic [VC_NUM-1:0] error_o;

    modport master (
        output valid_i, flit_i, read_i, read_vc_i,
        input  flit_o, empty_o, full_o, head_o, credit_o, credit_vc_o, error_o
    );

    modport slave (
        input  valid_i, flit_i, read_i, read_vc_i,
        output flit_o, empty_o, full_o, head_o, credit_o, credit_vc_o, error_o
    );
endinterface

// File: rtl/vc_input_buffer.sv
// Virtual-channel router input port: per-VC FWFT flit FIFOs with packet-framing
// checks, sticky error flags and a registered one-per-pop credit return.
module vc_input_buffer #(
    parameter int unsigned VC_NUM       = 2,
    parameter int unsigned BUFFER_DEPTH = 4,
    parameter int unsigned MESH_SIZE_X  = 6,
    parameter int unsigned MESH_SIZE_Y  = 6,
    parameter int unsigned HEAD_PAYLOAD = 16
) (
    input logic               clk,
    input logic               rst_n,
    vc_input_buffer_if.slave  bus
);
    localparam int unsigned X_W    = $clog2(MESH_SIZE_X);
    localparam int unsigned Y_W    = $clog2(MESH_SIZE_Y);
    localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int unsigned FLIT_W = 2 + VC_W + X_W + Y_W + HEAD_PAYLOAD;
    localparam int unsigned CNT_W  = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned PTR_W  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    localparam logic [1:0] L_HEAD     = 2'd0;
    localparam logic [1:0] L_BODY     = 2'd1;
    localparam logic [1:0] L_TAIL     = 2'd2;
    localparam logic [1:0] L_HEADTAIL = 2'd3;

    typedef enum logic {S_IDLE, S_ACTIVE} frame_state_t;

    logic [FLIT_W-1:0] mem   [VC_NUM][BUFFER_DEPTH];
    logic [PTR_W-1:0]  wptr  [VC_NUM];
    logic [PTR_W-1:0]  rptr  [VC_NUM];
    logic [CNT_W-1:0]  cnt   [VC_NUM];
    frame_state_t      state [VC_NUM];
    logic [FLIT_W-1:0] front [VC_NUM];

    logic [VC_NUM-1:0] wr_sel;
    logic [VC_NUM-1:0] frame_ok;
    logic [VC_NUM-1:0] accept;
    logic [VC_NUM-1:0] pop;
    logic [VC_NUM-1:0] err_set;
    logic [VC_NUM-1:0] empty;
    logic [VC_NUM-1:0] full;
    logic [VC_NUM-1:0] head;
    logic [VC_NUM-1:0] error_q;
    logic              credit_q;
    logic [VC_W-1:0]   credit_vc_q;
    logic [FLIT_W-1:0] flit_sel;

    logic [1:0]        in_label;
    logic [VC_W-1:0]   in_vc;

    assign in_label = bus.flit_i[FLIT_W-1 -: 2];
    assign in_vc    = bus.flit_i[FLIT_W-3 -: VC_W];

    // Per-VC write acceptance, framing check, pop qualification and status.
    // An out-of-range vc_id or read_vc_i never matches any v, so it is ignored.
    always_comb begin
        wr_sel   = '0;
        frame_ok = '0;
        accept   = '0;
        pop      = '0;
        err_set  = '0;
        empty    = '0;
        full     = '0;
        head     = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            front[v]    = mem[v][rptr[v]];
            empty[v]    = (cnt[v] == '0);
            full[v]     = (cnt[v] == CNT_W'(BUFFER_DEPTH));
            head[v]     = !empty[v] && ((front[v][FLIT_W-1 -: 2] == L_HEAD) ||
                                        (front[v][FLIT_W-1 -: 2] == L_HEADTAIL));
            wr_sel[v]   = bus.valid_i && (in_vc == VC_W'(v));
            pop[v]      = bus.read_i && (bus.read_vc_i == VC_W'(v)) && !empty[v];
            if (state[v] == S_IDLE)
                frame_ok[v] = (in_label == L_HEAD) || (in_label == L_HEADTAIL);
            else
                frame_ok[v] = (in_label == L_BODY) || (in_label == L_TAIL);
            accept[v]   = wr_sel[v] && frame_ok[v] && (!full[v] || pop[v]);
            err_set[v]  = wr_sel[v] && !accept[v];
        end
    end

    // First-word fall-through view of the selected VC; zero when nothing to show.
    always_comb begin
        flit_sel = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if ((bus.read_vc_i == VC_W'(v)) && !empty[v])
                flit_sel = front[v];
        end
    end

    // Flit storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (accept[v])
                mem[v][wptr[v]] <= bus.flit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_NUM; v++) begin
                wptr[v]  <= '0;
                rptr[v]  <= '0;
                cnt[v]   <= '0;
                state[v] <= S_IDLE;
            end
            error_q     <= '0;
            credit_q    <= 1'b0;
            credit_vc_q <= '0;
        end else begin
            credit_q    <= |pop;
            credit_vc_q <= '0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (pop[v])
                    credit_vc_q <= VC_W'(v);
                if (accept[v]) begin
                    wptr[v] <= (wptr[v] == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wptr[v] + PTR_W'(1);
                    if ((state[v] == S_IDLE) && (in_label == L_HEAD))
                        state[v] <= S_ACTIVE;
                    else if ((state[v] == S_ACTIVE) && (in_label == L_TAIL))
                        state[v] <= S_IDLE;
                end
                if (pop[v])
                    rptr[v] <= (rptr[v] == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rptr[v] + PTR_W'(1);
                case ({accept[v], pop[v]})
                    2'b10:   cnt[v] <= cnt[v] + CNT_W'(1);
                    2'b01:   cnt[v] <= cnt[v] - CNT_W'(1);
                    default: cnt[v] <= cnt[v];
                endcase
                if (err_set[v])
                    error_q[v] <= 1'b1;
            end
        end
    end

    assign bus.flit_o      = flit_sel;
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.head_o      = head;
    assign bus.credit_o    = credit_q;
    assign bus.credit_vc_o = credit_vc_q;
    assign bus.error_o     = error_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer with default parameters (2 VCs, depth 4, 25-bit flits).
module tb_vc_input_buffer;
    localparam int unsigned VC_NUM = 2;
    localparam int unsigned VC_W   = 1;
    localparam int unsigned FLIT_W = 25;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    vc_input_buffer_if #(.VC_NUM(VC_NUM), .VC_W(VC_W), .FLIT_W(FLIT_W)) bus ();

    vc_input_buffer #(
        .VC_NUM(2), .BUFFER_DEPTH(4), .MESH_SIZE_X(6), .MESH_SIZE_Y(6), .HEAD_PAYLOAD(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] lb, input logic vc,
                                             input logic [21:0] d);
        return {lb, vc, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [FLIT_W-1:0] f);
        bus.valid_i = 1'b1;
        bus.flit_i  = f;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_error", 32'(bus.error_o), 32'h0);
        #2;
        rst_n = 1'b1;
    endtask

    logic [FLIT_W-1:0] h1, b1, t1, h0, b0a, b0b, t0, x5, hn, ha, hb, ht0a, ht0b, hv1, bv1;

    initial begin
        n_cmp = 0;
        n_err = 0;
        h1   = mk(2'd0, 1'b1, 22'h0001A5);
        b1   = mk(2'd1, 1'b1, 22'h0000B1);
        t1   = mk(2'd2, 1'b1, 22'h0000C1);
        h0   = mk(2'd0, 1'b0, 22'h000010);
        b0a  = mk(2'd1, 1'b0, 22'h000011);
        b0b  = mk(2'd1, 1'b0, 22'h000012);
        t0   = mk(2'd2, 1'b0, 22'h000013);
        x5   = mk(2'd0, 1'b0, 22'h000015);
        hn   = mk(2'd0, 1'b0, 22'h000020);
        ha   = mk(2'd0, 1'b0, 22'h000030);
        hb   = mk(2'd0, 1'b0, 22'h000031);
        ht0a = mk(2'd3, 1'b0, 22'h000040);
        ht0b = mk(2'd3, 1'b0, 22'h000042);
        hv1  = mk(2'd0, 1'b1, 22'h000041);
        bv1  = mk(2'd1, 1'b1, 22'h000043);

        rst_n         = 1'b0;
        bus.valid_i   = 1'b0;
        bus.flit_i    = '0;
        bus.read_i    = 1'b0;
        bus.read_vc_i = '0;
        #2;
        chk("reset_empty",  32'(bus.empty_o),     32'h3);
        chk("reset_full",   32'(bus.full_o),      32'h0);
        chk("reset_head",   32'(bus.head_o),      32'h0);
        chk("reset_credit", 32'(bus.credit_o),    32'h0);
        chk("reset_cvc",    32'(bus.credit_vc_o), 32'h0);
        chk("reset_error",  32'(bus.error_o),     32'h0);
        chk("reset_flit",   32'(bus.flit_o),      32'h0);
        #6;
        rst_n = 1'b1;
        tick();

        // Packet on VC1, then drain it
        wr(h1);
        chk("t1_empty_after_head", 32'(bus.empty_o), 32'h1);
        bus.read_vc_i = 1'b1;
        #1;
        chk("t1_head_o", 32'(bus.head_o), 32'h2);
        chk("t1_flit_head", 32'(bus.flit_o), 32'(h1));
        wr(b1);
        wr(t1);
        chk("t1_full_none", 32'(bus.full_o), 32'h0);
        bus.read_i = 1'b1;
        tick();
        chk("t1_pop1_credit", 32'(bus.credit_o), 32'h1);
        chk("t1_pop1_cvc", 32'(bus.credit_vc_o), 32'h1);
        chk("t1_pop1_flit", 32'(bus.flit_o), 32'(b1));
        tick();
        chk("t1_pop2_credit", 32'(bus.credit_o), 32'h1);
        chk("t1_pop2_flit", 32'(bus.flit_o), 32'(t1));
        tick();
        chk("t1_pop3_credit", 32'(bus.credit_o), 32'h1);
        chk("t1_pop3_cvc", 32'(bus.credit_vc_o), 32'h1);
        chk("t1_empty_end", 32'(bus.empty_o), 32'h3);
        tick();
        chk("t1_read_empty_no_credit", 32'(bus.credit_o), 32'h0);
        bus.read_i = 1'b0;
        chk("t1_error", 32'(bus.error_o), 32'h0);

        // Fill VC0, overflow, then simultaneous write+pop on full VC
        bus.read_vc_i = 1'b0;
        wr(h0);
        wr(b0a);
        wr(b0b);
        wr(t0);
        chk("t2_full", 32'(bus.full_o), 32'h1);
        chk("t2_empty", 32'(bus.empty_o), 32'h2);
        chk("t2_front", 32'(bus.flit_o), 32'(h0));
        wr(x5);
        chk("t2_overflow_error", 32'(bus.error_o), 32'h1);
        chk("t2_still_full", 32'(bus.full_o), 32'h1);
        chk("t2_front_kept", 32'(bus.flit_o), 32'(h0));
        bus.valid_i = 1'b1;
        bus.flit_i  = hn;
        bus.read_i  = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        chk("t3_full_kept", 32'(bus.full_o), 32'h1);
        chk("t3_credit", 32'(bus.credit_o), 32'h1);
        chk("t3_cvc", 32'(bus.credit_vc_o), 32'h0);
        chk("t3_flit_b0a", 32'(bus.flit_o), 32'(b0a));
        tick();
        chk("t3_flit_b0b", 32'(bus.flit_o), 32'(b0b));
        tick();
        chk("t3_flit_t0", 32'(bus.flit_o), 32'(t0));
        tick();
        chk("t3_flit_new_last", 32'(bus.flit_o), 32'(hn));
        chk("t3_head_new", 32'(bus.head_o), 32'h1);
        tick();
        chk("t3_credit_last", 32'(bus.credit_o), 32'h1);
        chk("t3_empty", 32'(bus.empty_o), 32'h3);
        bus.read_i = 1'b0;

        // Framing errors on VC0
        do_reset();
        tick();
        wr(mk(2'd1, 1'b0, 22'h00002F));
        chk("t4_body_idle_error", 32'(bus.error_o), 32'h1);
        chk("t4_body_dropped", 32'(bus.empty_o), 32'h3);
        wr(ha);
        wr(hb);
        chk("t4_error_kept", 32'(bus.error_o), 32'h1);
        chk("t4_empty", 32'(bus.empty_o), 32'h2);
        chk("t4_front", 32'(bus.flit_o), 32'(ha));
        bus.read_i = 1'b1;
        tick();
        bus.read_i = 1'b0;
        chk("t4_credit", 32'(bus.credit_o), 32'h1);
        chk("t4_count_one", 32'(bus.empty_o), 32'h3);

        // Interleaved traffic on both VCs
        do_reset();
        tick();
        wr(ht0a);
        wr(hv1);
        wr(ht0b);
        wr(bv1);
        chk("t5_no_error", 32'(bus.error_o), 32'h0);
        chk("t5_head_both", 32'(bus.head_o), 32'h3);
        bus.read_vc_i = 1'b0;
        #1;
        chk("t5_vc0_front", 32'(bus.flit_o), 32'(ht0a));
        bus.read_vc_i = 1'b1;
        #1;
        chk("t5_vc1_front", 32'(bus.flit_o), 32'(hv1));
        wr(mk(2'd0, 1'b1, 22'h000044));
        chk("t5_vc1_active_head_err", 32'(bus.error_o), 32'h2);

        // Async reset with VC1 mid-packet
        bus.read_vc_i = 1'b0;
        bus.read_i    = 1'b1;
        tick();
        bus.read_i = 1'b0;
        chk("t6_credit_before_rst", 32'(bus.credit_o), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_empty",  32'(bus.empty_o),  32'h3);
        chk("t6_async_full",   32'(bus.full_o),   32'h0);
        chk("t6_async_head",   32'(bus.head_o),   32'h0);
        chk("t6_async_credit", 32'(bus.credit_o), 32'h0);
        chk("t6_async_error",  32'(bus.error_o),  32'h0);
        chk("t6_async_flit",   32'(bus.flit_o),   32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        wr(mk(2'd1, 1'b1, 22'h000045));
        chk("t6_body_after_rst_err", 32'(bus.error_o), 32'h2);
        chk("t6_body_dropped", 32'(bus.empty_o), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vc_input_buffer.md
# vc_input_buffer

Parametrised virtual-channel router input port: the VC-aware successor to the single-channel flit format, storing flits tagged with a VC ID in per-VC FIFOs. Each VC enforces packet framing (HEAD/BODY/TAIL/HEADTAIL) with its own state machine and returns one credit per dequeued flit to the upstream router. It sits between a mesh link and the router's route-compute/switch-allocation stage.

## Interface

Parameters:
- `VC_NUM`, 2, number of virtual channels (≥1).
- `BUFFER_DEPTH`, 4, flits per VC FIFO (≥2, need not be a power of two).
- `MESH_SIZE_X`, 6, mesh columns; `X_W = $clog2(MESH_SIZE_X)`.
- `MESH_SIZE_Y`, 6, mesh rows; `Y_W = $clog2(MESH_SIZE_Y)`.
- `HEAD_PAYLOAD`, 16, head payload bits.
- Derived: `VC_W = max(1,$clog2(VC_NUM))`; `FLIT_W = 2 + VC_W + X_W + Y_W + HEAD_PAYLOAD`.
- Flit layout, MSB first: `label[1:0]` (HEAD=0, BODY=1, TAIL=2, HEADTAIL=3), `vc_id[VC_W-1:0]`, then data `[X_W+Y_W+HEAD_PAYLOAD-1:0]`. For head flits the data field is x_dest, y_dest, payload.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_i` input 1: `flit_i` is valid this cycle.
- `flit_i` input FLIT_W: incoming flit; target VC taken from its `vc_id` field.
- `read_i` input 1: pop the front flit of VC `read_vc_i`.
- `read_vc_i` input VC_W: VC selected for `flit_o` and pop.
- `flit_o` output FLIT_W: front flit of VC `read_vc_i` (first-word fall-through).
- `empty_o` output VC_NUM: per-VC empty.
- `full_o` output VC_NUM: per-VC full.
- `head_o` output VC_NUM: per-VC, front flit is non-empty and labelled HEAD or HEADTAIL.
- `credit_o` output 1: one-cycle credit-return pulse.
- `credit_vc_o` output VC_W: VC of returned credit; valid when `credit_o`=1.
- `error_o` output VC_NUM: sticky per-VC framing/overflow error.

## Operation

- Per VC: circular buffer of BUFFER_DEPTH entries, write/read pointers wrapping from BUFFER_DEPTH-1 to 0, occupancy counter of `$clog2(BUFFER_DEPTH+1)` bits. `empty_o[v]` = count==0, `full_o[v]` = count==BUFFER_DEPTH.
- Write accepted when `valid_i`, `vc_id`<VC_NUM, the framing check passes, and the VC is not full or is being popped the same cycle.
- `vc_id`≥VC_NUM: flit dropped, no flag.
- Write to a full VC with no same-cycle pop: dropped, `error_o[v]` set.
- Per-VC framing FSM with states IDLE and ACTIVE, advanced only on an accepted write:
  - IDLE: HEAD goes to ACTIVE. HEADTAIL stays IDLE. BODY or TAIL is dropped and sets the error flag; state unchanged.
  - ACTIVE: BODY stays ACTIVE. TAIL goes to IDLE. HEAD or HEADTAIL is dropped and sets the error flag; state unchanged.
  - A framing-rejected flit never consumes buffer space.
- Read: when `read_i` and VC `read_vc_i` is non-empty, the read pointer advances and the count decrements. A read of an empty VC, or with `read_vc_i`≥VC_NUM, is ignored: no credit, no state change.
- A simultaneous write and read on the same VC leaves the count unchanged. Writes and reads on different VCs are independent.
- `flit_o` is combinational from the selected VC's read pointer. Its value is don't-care when that VC is empty or `read_vc_i`≥VC_NUM; drive it to 0 in that case.
- `error_o` bits clear only on reset.

## Timing

- Reset (async assert, sync-safe deassert): all pointers and counts 0, FSMs IDLE, `empty_o`=all 1, `full_o`=0, `head_o`=0, `credit_o`=0, `credit_vc_o`=0, `error_o`=0, `flit_o`=0.
- Reset mid-packet discards all stored flits and returns every FSM to IDLE. No credits are issued for discarded flits; upstream re-initialises its credits on reset.
- Write latency: a flit accepted at edge N appears on `flit_o`/`head_o`, and `empty_o` deasserts, after edge N (visible in cycle N+1).
- A pop at edge N updates `flit_o` to the next entry in cycle N+1. `credit_o`/`credit_vc_o` are registered and pulse high for exactly cycle N+1, one pulse per popped flit. Back-to-back pops give consecutive pulses.
- A full VC with pop and write at the same edge: both take effect, `full_o` stays 1, and one credit is issued.
- Throughput: one write and one read per cycle.

## Test plan

- Reset, then write HEAD, BODY, TAIL to VC1 on consecutive cycles. Expected: `empty_o`=2'b01 from the cycle after the first write; with `read_vc_i`=1, `head_o[1]`=1 and `flit_o` equals the HEAD flit. Then pop 3×. Expected: three `credit_o` pulses with `credit_vc_o`=1, VC1 empty, and `error_o`=0.
- Fill VC0 with 4 flits (HEAD, 2×BODY, TAIL), then write a 5th flit with no pop. Expected: `full_o[0]`=1, the 5th flit is dropped, `error_o[0]`=1, and pops return exactly the 4 original flits in order.
- With VC0 full, write and pop at the same edge. Expected: `full_o[0]` stays 1, one credit is issued, and the new flit is read out last.
- Write BODY to an idle VC0. Expected: it is dropped, `error_o[0]`=1, and `empty_o[0]` stays 1. Then write HEAD, then HEAD again. Expected: the second HEAD is dropped and the count is 1.
- Interleave a HEADTAIL on VC0 with a HEAD on VC1 in alternate cycles. Expected: VC0 FSM stays IDLE, VC1 goes ACTIVE, and there is no cross-VC corruption.
- Assert `rst_n`=0 asynchronously with VC1 mid-packet (2 flits stored). Expected: outputs take their reset values immediately without a clock edge. After release, a BODY on VC1 is rejected (FSM is IDLE).
